tx_frame_scheduler: RTL and testbench



---
 rtl/tx_frame_scheduler_if.sv | 25 ++
 rtl/tx_frame_scheduler.sv | 100 ++++++++++
 tb/tb_tx_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_scheduler_if.sv
// Sample-in / byte-out bundle between the ADC conversor, the frame scheduler and a tx_unit.
interface tx_frame_scheduler_if #(
    parameter int DATA_SIZE = 14
);
    logic                 i_adc_init;
    logic                 i_gate;
    logic                 i_sample_valid;
    logic [DATA_SIZE-1:0] i_ch1;
    logic [DATA_SIZE-1:0] i_ch2;
    logic                 i_txready;
    logic                 o_send;
    logic [7:0]           o_txdata;
    logic                 o_busy;
    logic                 o_overrun;

    modport master (
        output i_adc_init, i_gate, i_sample_valid, i_ch1, i_ch2, i_txready,
        input  o_send, o_txdata, o_busy, o_overrun
    );

    modport slave (
        input  i_adc_init, i_gate, i_sample_valid, i_ch1, i_ch2, i_txready,
        output o_send, o_txdata, o_busy, o_overrun
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Packs one CH1/CH2 sample pair into a 6-byte frame (header, seq, ch1 lo/hi, ch2 lo/hi)
// and feeds it byte by byte to a single tx_unit using its ready/idle handshake.
module tx_frame_scheduler #(
    parameter int         DATA_SIZE = 14,
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         DECIM     = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    tx_frame_scheduler_if.slave bus
);
    localparam int            CW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] DLAST = CW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, SEND, ACK, WAIT} state_t;

    state_t               state;
    logic [CW-1:0]        dcnt;
    logic [7:0]           seq;
    logic [DATA_SIZE-1:0] ch1_q;
    logic [DATA_SIZE-1:0] ch2_q;
    logic [2:0]           idx;
    logic [7:0]           cur_byte;
    logic                 armed;

    assign armed       = bus.i_gate & bus.i_adc_init;
    assign bus.o_busy  = (state != IDLE);

    // seq only advances once the frame is finished, so it doubles as the frame's SEQ byte
    always_comb begin
        cur_byte = HEADER;
        case (idx)
            3'd1:    cur_byte = seq;
            3'd2:    cur_byte = ch1_q[7:0];
            3'd3:    cur_byte = 8'(ch1_q >> 8);
            3'd4:    cur_byte = ch2_q[7:0];
            3'd5:    cur_byte = 8'(ch2_q >> 8);
            default: cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            dcnt          <= '0;
            seq           <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            idx           <= '0;
            bus.o_send    <= 1'b0;
            bus.o_txdata  <= '0;
            bus.o_overrun <= 1'b0;
        end else begin
            bus.o_send <= 1'b0;
            // includes the WAIT->IDLE edge: a strobe there is dropped, not captured
            if (bus.i_sample_valid && armed && state != IDLE)
                bus.o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (!armed) begin
                        dcnt <= '0;
                    end else if (bus.i_sample_valid) begin
                        if (dcnt == DLAST) begin
                            dcnt  <= '0;
                            ch1_q <= bus.i_ch1;
                            ch2_q <= bus.i_ch2;
                            idx   <= '0;
                            state <= SEND;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bus.i_txready) begin
                        bus.o_send   <= 1'b1;
                        bus.o_txdata <= cur_byte;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    if (!bus.i_txready) state <= WAIT;
                end
                WAIT: begin
                    if (bus.i_txready) begin
                        if (idx == 3'd5) begin
                            seq   <= seq + 8'd1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench: two schedulers (DECIM=1 and DECIM=4) against a frame-level model plus literal frame checks.
module tb_tx_frame_scheduler;
    localparam int DS = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          gate, init;
    logic [1:0]    valid, hold_lo;
    logic [1:0]    txr = 2'b11;
    logic [DS-1:0] ch1, ch2;
    logic [1:0]    snd, bsy, ovr;
    logic [7:0]    txd [2];

    int total = 0;
    int bad   = 0;

    tx_frame_scheduler_if #(.DATA_SIZE(DS)) bus0 ();
    tx_frame_scheduler_if #(.DATA_SIZE(DS)) bus1 ();

    assign bus0.i_adc_init = init;     assign bus1.i_adc_init = init;
    assign bus0.i_gate = gate;         assign bus1.i_gate = gate;
    assign bus0.i_ch1 = ch1;           assign bus1.i_ch1 = ch1;
    assign bus0.i_ch2 = ch2;           assign bus1.i_ch2 = ch2;
    assign bus0.i_sample_valid = valid[0];
    assign bus1.i_sample_valid = valid[1];
    assign bus0.i_txready = txr[0];
    assign bus1.i_txready = txr[1];
    assign snd[0] = bus0.o_send;   assign snd[1] = bus1.o_send;
    assign bsy[0] = bus0.o_busy;   assign bsy[1] = bus1.o_busy;
    assign ovr[0] = bus0.o_overrun; assign ovr[1] = bus1.o_overrun;
    assign txd[0] = bus0.o_txdata; assign txd[1] = bus1.o_txdata;

    tx_frame_scheduler #(.DATA_SIZE(DS), .HEADER(8'hA5), .DECIM(1)) dut0 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus0));
    tx_frame_scheduler #(.DATA_SIZE(DS), .HEADER(8'hA5), .DECIM(4)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus1));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: expected byte queues and frame-level status ----------------
    logic [7:0] q0[$], q1[$], log0[$], log1[$];
    int         cnt[2], m_dcnt[2], m_sent[2];
    bit         m_busy[2], m_ovr[2], m_ack[2], prev_snd[2];
    logic [7:0] m_seq[2], m_last[2];

    function automatic int decim(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic push6(input int k, input logic [7:0] s, input int a, input int b);
        logic [7:0] f [6];
        f[0] = 8'hA5; f[1] = s;
        f[2] = 8'(a % 256); f[3] = 8'(a / 256);
        f[4] = 8'(b % 256); f[5] = 8'(b / 256);
        for (int i = 0; i < 6; i++)
            if (k == 0) q0.push_back(f[i]); else q1.push_back(f[i]);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] e;
            bit         arm;
            if (!rst_n) begin
                cnt[k] = 0; m_dcnt[k] = 0; m_sent[k] = 0;
                m_busy[k] = 0; m_ovr[k] = 0; m_ack[k] = 0; prev_snd[k] = 0;
                m_seq[k] = 8'h00; m_last[k] = 8'h00;
                if (k == 0) q0.delete(); else q1.delete();
            end
            chk("busy", int'(bsy[k]), int'(m_busy[k]));
            chk("overrun", int'(ovr[k]), int'(m_ovr[k]));
            if (snd[k]) begin
                chk("send_back_to_back", int'(prev_snd[k]), 0);
                chk("send_without_ready", int'(txr[k]), 1);
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("unexpected_send", 1, 0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("txdata", int'(txd[k]), int'(e));
                end
                if (k == 0) log0.push_back(txd[k]); else log1.push_back(txd[k]);
                m_last[k] = txd[k];
                m_sent[k]++;
                m_ack[k] = 1;
                cnt[k] = 10;
            end else begin
                chk("txdata_hold", int'(txd[k]), int'(m_last[k]));
                if (cnt[k] > 0) cnt[k]--;
            end
            prev_snd[k] = snd[k];
            txr[k] = (cnt[k] == 0) && !hold_lo[k];

            // predict what the coming edge does, using the inputs now stable
            if (rst_n) begin
                arm = gate && init;
                if (!m_busy[k]) begin
                    if (!arm) m_dcnt[k] = 0;
                    else if (valid[k]) begin
                        if (m_dcnt[k] == decim(k) - 1) begin
                            m_dcnt[k] = 0;
                            push6(k, m_seq[k], int'(ch1), int'(ch2));
                            m_busy[k] = 1; m_sent[k] = 0; m_ack[k] = 0;
                        end else m_dcnt[k]++;
                    end
                end else begin
                    if (valid[k] && arm) m_ovr[k] = 1;
                    if (m_sent[k] == 6 && !m_ack[k] && txr[k]) begin
                        m_busy[k] = 0;
                        m_seq[k]  = m_seq[k] + 8'd1;
                    end else if (m_ack[k] && !txr[k]) m_ack[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (all start just after a rising edge) ----------------
    task automatic strobe(input int k, input logic [DS-1:0] a, input logic [DS-1:0] b);
        ch1 = a; ch2 = b; valid[k] = 1'b1;
        @(posedge clk); #1;
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 300; i++) begin
            if (!bsy[k]) return;
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 300; i++) begin
            if (log0.size() >= n) return;
            @(posedge clk); #1;
        end
        chk("wait_bytes_timeout", log0.size(), n);
    endtask

    function automatic logic [7:0] logb(input int k, input int i);
        if (k == 0) return (i < log0.size()) ? log0[i] : 8'hXX;
        return (i < log1.size()) ? log1[i] : 8'hXX;
    endfunction

    task automatic chk_frame(input string nm, input int k, input int base, input logic [47:0] f);
        for (int i = 0; i < 6; i++)
            chk(nm, int'(logb(k, base + i)), int'(f[47-8*i -: 8]));
    endtask

    initial begin
        int b;
        gate = 1'b1; init = 1'b1; valid = 2'b00; hold_lo = 2'b00;
        ch1 = '0; ch2 = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_send", int'(snd), 0);
        chk("reset_txdata", int'(txd[0]), 0);
        chk("reset_busy", int'(bsy), 0);
        chk("reset_overrun", int'(ovr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // first frame and capture latency
        b = log0.size();
        strobe(0, 14'h1ABC, 14'h0123);
        chk("capture_busy", int'(bsy[0]), 1);
        chk("capture_no_send_yet", int'(snd[0]), 0);
        @(posedge clk); #1;
        chk("first_send", int'(snd[0]), 1);
        chk("first_byte", int'(txd[0]), 8'hA5);
        wait_idle(0);
        chk_frame("frame1", 0, b, 48'hA5_00_BC_1A_23_01);

        // back-to-back frames, then run SEQ around its wrap
        for (int f = 2; f <= 257; f++) begin
            strobe(0, DS'(f * 37), DS'(f * 91));
            wait_idle(0);
        end
        chk("seq_frame2", int'(logb(0, 6 + 1)), 8'h01);
        chk("seq_frame3", int'(logb(0, 12 + 1)), 8'h02);
        chk("seq_frame256", int'(logb(0, 255 * 6 + 1)), 8'hFF);
        chk("seq_frame257", int'(logb(0, 256 * 6 + 1)), 8'h00);

        // overrun: second strobe during a frame is dropped
        b = log0.size();
        strobe(0, 14'h2222, 14'h3333);
        repeat (3) @(posedge clk);
        #1;
        strobe(0, 14'h3FFF, 14'h3EEE);
        chk("overrun_set", int'(ovr[0]), 1);
        wait_idle(0);
        chk_frame("overrun_frame", 0, b, 48'hA5_01_22_22_33_33);
        chk("overrun_sticky", int'(ovr[0]), 1);
        chk("overrun_no_extra_bytes", log0.size(), b + 6);

        // tx_unit not ready at capture; gate falls mid-frame
        b = log0.size();
        hold_lo[0] = 1'b1;
        strobe(0, 14'h0ABC, 14'h1DEF);
        for (int i = 0; i < 20; i++) begin
            chk("held_no_send", int'(snd[0]), 0);
            @(posedge clk); #1;
        end
        hold_lo[0] = 1'b0;
        wait_bytes(b + 3);
        gate = 1'b0;
        wait_idle(0);
        gate = 1'b1;
        chk_frame("gate_fall_frame", 0, b, 48'hA5_02_BC_0A_EF_1D);

        // decimation by 4 on the second instance, gate-low strobes clear the count
        for (int j = 1; j <= 2; j++) begin
            strobe(1, 14'h3FFF, 14'h3FFF);
            @(posedge clk); #1;
        end
        gate = 1'b0;
        for (int j = 0; j < 5; j++) begin
            strobe(1, 14'h3F3F, 14'h3F3F);
            @(posedge clk); #1;
        end
        gate = 1'b1;
        chk("decim_no_early_frame", log1.size(), 0);
        for (int j = 1; j <= 8; j++) begin
            strobe(1, DS'(16'h0101 * j), DS'(16'h2000 + j));
            wait_idle(1);
            @(posedge clk); #1;
        end
        chk("decim_byte_count", log1.size(), 12);
        chk_frame("decim_frame_a", 1, 0, 48'hA5_00_04_04_04_20);
        chk_frame("decim_frame_b", 1, 6, 48'hA5_01_08_08_08_20);

        // asynchronous reset mid-frame, then a fresh frame
        b = log0.size();
        strobe(0, 14'h1111, 14'h0222);
        wait_bytes(b + 4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_send", int'(snd[0]), 0);
        chk("async_rst_txdata", int'(txd[0]), 0);
        chk("async_rst_busy", int'(bsy[0]), 0);
        chk("async_rst_overrun", int'(ovr[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        b = log0.size();
        strobe(0, 14'h0055, 14'h0066);
        wait_idle(0);
        chk_frame("after_reset_frame", 0, b, 48'hA5_00_55_00_66_00);

        repeat (5) @(posedge clk);
        #1;
        chk("model_queue0_drained", q0.size(), 0);
        chk("model_queue1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
